// File: rtl/potential_adder_scheduler.sv
// Time-multiplexes one LIF potential adder across NUM_NEURONS neurons.
// Owns the membrane-potential store and collects the per-timestep spike vector.
//
// state  | meaning
// IDLE   | waiting for step_start
// CLEAR  | pulse adder_clear, wipe spike accumulator
// SET    | pulse adder_set
// ACCEPT | evt_ready high, take an event or finish the timestep
// ISSUE  | adder inputs presented for the latched event
// WAIT   | adder settling, dwell of ADDER_LAT cycles
// WRITE  | write back adder result and spike flag
// DONE   | publish spikes, pulse done
module potential_adder_scheduler #(
  parameter int NUM_NEURONS = 30,
  parameter int IDX_W       = 5,
  parameter int ADDER_LAT   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   step_start,
  input  logic                   step_end,
  input  logic                   evt_valid,
  output logic                   evt_ready,
  input  logic [IDX_W-1:0]       evt_idx,
  input  logic [31:0]            evt_weight,
  output logic                   adder_clear,
  output logic                   adder_set,
  output logic [31:0]            adder_weight,
  output logic [31:0]            adder_potential,
  input  logic [31:0]            adder_final,
  input  logic                   adder_spike,
  output logic [NUM_NEURONS-1:0] spikes,
  output logic                   done,
  output logic                   busy,
  output logic                   err_idx,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [31:0]            rd_potential
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SET, S_ACCEPT, S_ISSUE, S_WAIT, S_WRITE, S_DONE
  } state_t;

  localparam int CNT_W = (ADDER_LAT > 1) ? $clog2(ADDER_LAT) : 1;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(ADDER_LAT - 1);
  localparam logic [IDX_W:0] NUM_N = (IDX_W + 1)'(NUM_NEURONS);

  state_t state, state_nx;

  logic [31:0]            mem [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] acc;
  logic                   end_pending;
  logic [IDX_W-1:0]       idx_q;
  logic [CNT_W-1:0]       wait_cnt;
  logic                   evt_in_range;
  logic                   rd_in_range;
  logic                   accept;

  assign evt_in_range = ({1'b0, evt_idx} < NUM_N);
  assign rd_in_range  = ({1'b0, rd_idx} < NUM_N);
  assign rd_potential = rd_in_range ? mem[rd_idx] : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    evt_ready   = 1'b0;
    adder_clear = 1'b0;
    adder_set   = 1'b0;
    done        = 1'b0;
    accept      = 1'b0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE:  if (step_start) state_nx = S_CLEAR;
      S_CLEAR: begin
        adder_clear = 1'b1;
        state_nx    = S_SET;
      end
      S_SET: begin
        adder_set = 1'b1;
        state_nx  = S_ACCEPT;
      end
      S_ACCEPT: begin
        evt_ready = 1'b1;
        if (evt_valid) begin
          accept = 1'b1;
          // bad indices are swallowed here and never reach the adder
          state_nx = evt_in_range ? S_ISSUE : S_ACCEPT;
        end else if (end_pending) begin
          state_nx = S_DONE;
        end
      end
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (wait_cnt == '0) state_nx = S_WRITE;
      S_WRITE: state_nx = S_ACCEPT;
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) mem[i] <= 32'h0;
      acc             <= '0;
      spikes          <= '0;
      end_pending     <= 1'b0;
      err_idx         <= 1'b0;
      idx_q           <= '0;
      wait_cnt        <= '0;
      adder_weight    <= 32'h0;
      adder_potential <= 32'h0;
    end else begin
      if (state == S_DONE)
        end_pending <= 1'b0;
      else if (step_end && state != S_IDLE)
        end_pending <= 1'b1;

      // adder inputs load on acceptance so they are stable from ISSUE through WRITE
      if (accept) begin
        idx_q <= evt_idx;
        if (evt_in_range) begin
          adder_weight    <= evt_weight;
          adder_potential <= mem[evt_idx];
        end else begin
          err_idx <= 1'b1;
        end
      end

      if (state == S_ISSUE)
        wait_cnt <= WAIT_INIT;
      else if (state == S_WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - 1'b1;

      if (state == S_CLEAR)
        acc <= '0;
      else if (state == S_WRITE)
        acc[idx_q] <= acc[idx_q] | adder_spike;

      if (state == S_WRITE)
        mem[idx_q] <= adder_final;

      // publish on entry to DONE so spikes is valid while done is high
      if (state == S_ACCEPT && state_nx == S_DONE)
        spikes <= acc;
    end
  end

endmodule

// File: tb/tb_potential_adder_scheduler.sv
// Bench for potential_adder_scheduler: behavioural LIF adder (threshold 40.0)
// plus a scoreboard of expected adder inputs and a model of the potential store.
module tb_potential_adder_scheduler;
  localparam int NUM_NEURONS = 30;
  localparam int IDX_W       = 5;
  localparam int ADDER_LAT   = 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   step_start = 1'b0;
  logic                   step_end = 1'b0;
  logic                   evt_valid = 1'b0;
  logic                   evt_ready;
  logic [IDX_W-1:0]       evt_idx = '0;
  logic [31:0]            evt_weight = 32'h0;
  logic                   adder_clear, adder_set;
  logic [31:0]            adder_weight, adder_potential, adder_final;
  logic                   adder_spike;
  logic [NUM_NEURONS-1:0] spikes;
  logic                   done, busy, err_idx;
  logic [IDX_W-1:0]       rd_idx = '0;
  logic [31:0]            rd_potential;

  potential_adder_scheduler #(
    .NUM_NEURONS(NUM_NEURONS), .IDX_W(IDX_W), .ADDER_LAT(ADDER_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .step_start(step_start), .step_end(step_end),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_idx(evt_idx),
    .evt_weight(evt_weight), .adder_clear(adder_clear), .adder_set(adder_set),
    .adder_weight(adder_weight), .adder_potential(adder_potential),
    .adder_final(adder_final), .adder_spike(adder_spike), .spikes(spikes),
    .done(done), .busy(busy), .err_idx(err_idx), .rd_idx(rd_idx),
    .rd_potential(rd_potential)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] w; logic [31:0] p; } issue_t;
  issue_t                 exp_q[$];
  logic [31:0]            model_mem [32];
  logic [NUM_NEURONS-1:0] model_acc = '0;
  int n_checks = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0, done_cnt = 0, clear_cnt = 0;
  real sum_r;

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  // stand-in for the shared adder: sum, compare to 40.0, subtract on spike
  always_comb begin
    sum_r       = f2r(adder_potential) + f2r(adder_weight);
    adder_spike = (sum_r >= 40.0);
    adder_final = r2f(adder_spike ? sum_r - 40.0 : sum_r);
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done)        done_cnt  <= done_cnt + 1;
    if (adder_clear) clear_cnt <= clear_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
    model_acc = '0;
    exp_q.delete();
  endtask

  task automatic step_begin();
    @(posedge clk); #1 step_start = 1'b1;
    @(posedge clk); #1 step_start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic pulse_end();
    step_end = 1'b1;
    @(posedge clk); #1 step_end = 1'b0;
  endtask

  task automatic send_event(input logic [IDX_W-1:0] idx, input logic [31:0] w,
                            input logic [31:0] exp_after, input logic exp_spike,
                            input logic with_end);
    int     waited = 0;
    logic   got = 1'b0;
    logic   in_range;
    issue_t e;
    in_range   = (int'(idx) < NUM_NEURONS);
    evt_idx    = idx;
    evt_weight = w;
    evt_valid  = 1'b1;
    step_end   = with_end;
    if (in_range) begin
      exp_q.push_back('{w: w, p: model_mem[idx]});
      model_mem[idx] = exp_after;
      if (exp_spike) model_acc[idx] = 1'b1;
    end
    while (!got && waited < 50) begin
      @(negedge clk);
      if (evt_ready) got = 1'b1;
      @(posedge clk); #1;
      waited++;
    end
    evt_valid = 1'b0;
    step_end  = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL handshake_timeout: idx %0d not accepted within %0d cycles", idx, waited);
      if (in_range && exp_q.size() > 0) e = exp_q.pop_back();
      return;
    end
    @(negedge clk);
    if (in_range) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: no expected issue for idx %0d", idx);
        return;
      end
      e = exp_q.pop_front();
      n_checks++;
      if (adder_weight !== e.w) begin
        n_fail++;
        $display("FAIL issue_weight idx %0d: got %h expected %h", idx, adder_weight, e.w);
      end
      n_checks++;
      if (adder_potential !== e.p) begin
        n_fail++;
        $display("FAIL issue_potential idx %0d: got %h expected %h", idx, adder_potential, e.p);
      end
      for (int k = 0; k < ADDER_LAT + 2; k++) begin
        if (k > 0) @(negedge clk);
        n_checks++;
        if (evt_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL ready_low_busy idx %0d cycle %0d: got %b expected 0", idx, k, evt_ready);
        end
      end
    end else begin
      n_checks++;
      if (evt_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL bad_idx_ready idx %0d: got %b expected 1", idx, evt_ready);
      end
      n_checks++;
      if (err_idx !== 1'b1) begin
        n_fail++;
        $display("FAIL err_idx idx %0d: got %b expected 1", idx, err_idx);
      end
    end
  endtask

  task automatic wait_done(input logic check_lat);
    int   n = 0;
    logic got = 1'b0;
    int   lat;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", n);
      return;
    end
    n_checks++;
    if (spikes !== model_acc) begin
      n_fail++;
      $display("FAIL spikes: got %h expected %h", spikes, model_acc);
    end
    if (check_lat) begin
      lat = cyc - start_cyc + 1;
      n_checks++;
      if (lat != 1 + 1 + 1 + (ADDER_LAT + 3) + 1) begin
        n_fail++;
        $display("FAIL done_latency: got %0d expected %0d", lat, 1 + 1 + 1 + (ADDER_LAT + 3) + 1);
      end
    end
    model_acc = '0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL after_done_idle: busy %b done %b expected 0 0", busy, done);
    end
  endtask

  task automatic check_mem(input string tag);
    logic [31:0] expv;
    for (int i = 0; i < 32; i++) begin
      rd_idx = i[IDX_W-1:0];
      #1;
      expv = (i < NUM_NEURONS) ? model_mem[i] : 32'h0;
      n_checks++;
      if (rd_potential !== expv) begin
        n_fail++;
        $display("FAIL mem_%s[%0d]: got %h expected %h", tag, i, rd_potential, expv);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({evt_ready, busy, done, err_idx, adder_clear, adder_set} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {evt_ready, busy, done, err_idx, adder_clear, adder_set});
    end
    n_checks++;
    if (adder_weight !== 32'h0 || adder_potential !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_adder_bus: got %h/%h expected 0/0", adder_weight, adder_potential);
    end
    n_checks++;
    if (spikes !== '0) begin
      n_fail++;
      $display("FAIL reset_spikes: got %h expected 0", spikes);
    end
    rst_n = 1'b1;
    check_mem("reset");
  endtask

  task automatic test_single_event();
    step_begin();
    send_event(5'd3, 32'h41A00000, 32'h41A00000, 1'b0, 1'b1);
    wait_done(1'b1);
    check_mem("single");
  endtask

  task automatic test_spike();
    step_begin();
    send_event(5'd7, 32'h41C80000, 32'h41C80000, 1'b0, 1'b0);
    send_event(5'd7, 32'h41C80000, 32'h41200000, 1'b1, 1'b0);
    pulse_end();
    wait_done(1'b0);
    check_mem("spike");
  endtask

  task automatic test_back_to_back();
    step_begin();
    send_event(5'd0, 32'h41200000, 32'h41200000, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    send_event(5'd1, 32'h41200000, 32'h41200000, 1'b0, 1'b0);
    send_event(5'd2, 32'h41200000, 32'h41200000, 1'b0, 1'b0);
    pulse_end();
    wait_done(1'b0);
    check_mem("b2b");
  endtask

  task automatic test_end_with_last();
    int clear_before;
    int done_before;
    clear_before = clear_cnt;
    done_before  = done_cnt;
    step_begin();
    send_event(5'd10, 32'h41200000, 32'h41200000, 1'b0, 1'b0);
    step_start = 1'b1;
    send_event(5'd10, 32'h40A00000, 32'h41700000, 1'b0, 1'b1);
    step_start = 1'b0;
    wait_done(1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (clear_cnt - clear_before != 1) begin
      n_fail++;
      $display("FAIL restart_ignored: got %0d clear pulses expected 1", clear_cnt - clear_before);
    end
    n_checks++;
    if (done_cnt - done_before != 1) begin
      n_fail++;
      $display("FAIL done_count: got %0d expected 1", done_cnt - done_before);
    end
    check_mem("endlast");
  endtask

  task automatic test_err_idx();
    @(negedge clk);
    n_checks++;
    if (err_idx !== 1'b0) begin
      n_fail++;
      $display("FAIL err_idx_clean: got %b expected 0", err_idx);
    end
    step_begin();
    send_event(5'd30, 32'h41200000, 32'h0, 1'b0, 1'b0);
    send_event(5'd31, 32'h41200000, 32'h0, 1'b0, 1'b0);
    pulse_end();
    wait_done(1'b0);
    n_checks++;
    if (err_idx !== 1'b1) begin
      n_fail++;
      $display("FAIL err_idx_sticky: got %b expected 1", err_idx);
    end
    check_mem("err");
  endtask

  task automatic test_reset_mid_step();
    int   waited = 0;
    logic got = 1'b0;
    int   done_before;
    step_begin();
    evt_idx    = 5'd5;
    evt_weight = 32'h41200000;
    evt_valid  = 1'b1;
    while (!got && waited < 50) begin
      @(negedge clk);
      if (evt_ready) got = 1'b1;
      @(posedge clk); #1;
      waited++;
    end
    evt_valid = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL rst_handshake_timeout: not accepted within %0d cycles", waited);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    done_before = done_cnt;
    model_clear();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_in_wait: got %b expected 1", busy);
    end
    @(negedge clk);
    n_checks++;
    if ({evt_ready, busy, done, err_idx, adder_clear, adder_set} !== 6'b0) begin
      n_fail++;
      $display("FAIL midrst_ctrl: got %b expected 000000",
               {evt_ready, busy, done, err_idx, adder_clear, adder_set});
    end
    n_checks++;
    if (adder_weight !== 32'h0 || adder_potential !== 32'h0 || spikes !== '0) begin
      n_fail++;
      $display("FAIL midrst_data: got %h/%h/%h expected 0/0/0", adder_weight, adder_potential, spikes);
    end
    check_mem("midrst");
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt != done_before) begin
      n_fail++;
      $display("FAIL midrst_no_done: got %0d done pulses expected 0", done_cnt - done_before);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_spike();
    test_back_to_back();
    test_end_with_last();
    test_err_idx();
    test_reset_mid_step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
